// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter: FSM states, byte-enable
// patterns and port indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // A store that touches some but not all bytes needs a read-modify-write.
  function automatic logic is_partial(input logic [3:0] be);
    return (be != BE_FULL) && (be != BE_NONE);
  endfunction

endpackage

// File: rtl/dmem_arbiter_byte_merge.sv
// Per-byte select between the word read from memory and the new store data.
module byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = be[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a word-only single-port dmem; sequences
// reads, full writes and read-modify-write byte stores.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state_reg, state_next;
  logic        win_reg;
  logic        last_reg;
  logic        we_reg;
  logic [3:0]  be_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merged_reg;
  logic [31:0] rdata_reg;

  logic        grant;
  logic [31:0] merged_word;
  logic        mem_read_raw;
  logic        mem_write_raw;

  byte_merge u_merge (
    .old_word (mem_rdata),
    .new_word (wdata_reg),
    .be       (be_reg),
    .merged   (merged_word)
  );

  // On contention the pointer names the last port served; the other one wins.
  always_comb begin
    grant = PORT0;
    if (req == 2'b10) begin
      grant = PORT1;
    end else if ((req == 2'b11) && RR_EN && (last_reg == PORT0)) begin
      grant = PORT1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = ACCESS;
      ACCESS:  state_next = (we_reg && is_partial(be_reg)) ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    ack           = 2'b00;
    case (state_reg)
      ACCESS: begin
        mem_addr = addr_reg;
        if (!we_reg) begin
          mem_read_raw = 1'b1;
        end else if (be_reg == BE_FULL) begin
          mem_write_raw = 1'b1;
          mem_wdata     = wdata_reg;
        end else if (be_reg != BE_NONE) begin
          mem_read_raw = 1'b1;
        end
      end
      WRITE: begin
        mem_addr      = addr_reg;
        mem_write_raw = 1'b1;
        mem_wdata     = merged_reg;
      end
      DONE:    ack = win_reg ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Strobes are gated with reset so an abandoned store never commits.
  assign mem_read  = mem_read_raw & ~rst;
  assign mem_write = mem_write_raw & ~rst;
  assign busy      = (state_reg != IDLE);
  assign rdata     = rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_reg    <= PORT0;
      last_reg   <= PORT1;
      we_reg     <= 1'b0;
      be_reg     <= BE_NONE;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      merged_reg <= 32'h0;
      rdata_reg  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            win_reg   <= grant;
            we_reg    <= grant ? we[1] : we[0];
            be_reg    <= grant ? be1 : be0;
            addr_reg  <= (grant ? addr1 : addr0) & WORD_MASK;
            wdata_reg <= grant ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          if (!we_reg) begin
            rdata_reg <= mem_rdata;
          end else if (is_partial(be_reg)) begin
            merged_reg <= merged_word;
          end
        end
        DONE:    last_reg <= win_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a 16-word dmem model.
module tb_dmem_arbiter;

  localparam int DEPTH = 16;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic        port;
    logic        is_read;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          cyc;
    int          nrd;
    int          nwr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [3:0]  be0 = 4'h0, be1 = 4'h0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        busy, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Second instance in fixed-priority mode, used only for the starvation check.
  logic [1:0]  fp_req = 2'b00;
  logic [1:0]  fp_we = 2'b00;
  logic [3:0]  fp_be = 4'h0;
  logic [31:0] fp_zero = 32'h0;
  logic [1:0]  fp_ack;
  logic [31:0] fp_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_busy, fp_mem_read, fp_mem_write;

  dmem_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be0(be0), .be1(be1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req(fp_req), .we(fp_we), .be0(fp_be), .be1(fp_be),
    .addr0(fp_zero), .addr1(fp_zero), .wdata0(fp_zero), .wdata1(fp_zero),
    .ack(fp_ack), .rdata(fp_rdata), .busy(fp_busy), .mem_read(fp_mem_read),
    .mem_write(fp_mem_write), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_rdata(fp_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dmem: combinational read, posedge write, out-of-range reads 0 / writes dropped
  logic        mem_clr = 1'b1;
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (mem_write && (mem_addr < 32'(DEPTH * 4))) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < 32'(DEPTH * 4)) ? mem[mem_addr[5:2]] : 32'h0;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, req_v, cyc);
    end
  endtask

  // Reference model: a shadow word array plus last-served port.
  logic [31:0] ref_mem [DEPTH];
  int          rr_last = 1;
  exp_t        sb_q[$];

  function automatic op_t mk(input logic w, input logic [3:0] b, input logic [31:0] a,
                             input logic [31:0] d);
    op_t o;
    o.we = w; o.be = b; o.addr = a; o.wdata = d;
    return o;
  endfunction

  task automatic model_apply(input logic port, input op_t op, input int start,
                             output exp_t e, output int lat);
    bit inr;
    int idx;
    inr = (op.addr < 32'(DEPTH * 4));
    idx = inr ? int'(op.addr >> 2) : 0;
    e.port = port; e.is_read = !op.we; e.addr = op.addr & 32'hFFFF_FFFC;
    e.rdata = 32'h0; e.nrd = 0; e.nwr = 0; lat = 2;
    if (!op.we) begin
      e.nrd = 1;
      if (inr) e.rdata = ref_mem[idx];
    end else if (op.be == 4'hF) begin
      e.nwr = 1;
      if (inr) ref_mem[idx] = op.wdata;
    end else if (op.be != 4'h0) begin
      e.nrd = 1; e.nwr = 1; lat = 3;
      if (inr) for (int b = 0; b < 4; b++)
        if (op.be[b]) ref_mem[idx][8*b +: 8] = op.wdata[8*b +: 8];
    end
    e.cyc = start + lat;
  endtask

  // Issue one access (ports = 01/10) or a simultaneous pair (11); hold until acked.
  task automatic run(input logic [1:0] ports, input op_t o0, input op_t o1);
    exp_t e;
    int   lat, c;
    logic first;
    @(negedge clk);
    c = cyc;
    first = (ports == 2'b11) ? (rr_last == 0) : ports[1];
    model_apply(first, first ? o1 : o0, c, e, lat);
    sb_q.push_back(e);
    rr_last = int'(first);
    if (ports == 2'b11) begin
      model_apply(!first, first ? o0 : o1, c + lat + 1, e, lat);
      sb_q.push_back(e);
      rr_last = int'(!first);
    end
    we = {o1.we, o0.we};
    be0 = o0.be; addr0 = o0.addr; wdata0 = o0.wdata;
    be1 = o1.be; addr1 = o1.addr; wdata1 = o1.wdata;
    req = ports;
    for (int k = 0; k < 40 && req != 2'b00; k++) begin
      @(negedge clk);
      if (req[0] && ack[0]) req[0] = 1'b0;
      if (req[1] && ack[1]) req[1] = 1'b0;
    end
    if (req != 2'b00) begin
      check("ack_timeout", {30'b0, req}, 32'h0);
      req = 2'b00;
      sb_q.delete();
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks port, timing, data, strobes.
  int   rd_cnt = 0, wr_cnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0; wr_cnt = 0;
    end else begin
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (ack == 2'b11) begin
        check("ack_both", {30'b0, ack}, 32'h1);
      end else if (ack != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("ack_unexpected", {30'b0, ack}, 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          check("ack_port", {30'b0, ack}, mon_e.port ? 32'h2 : 32'h1);
          check("ack_cycle", cyc, mon_e.cyc);
          if (mon_e.is_read) check("rdata", rdata, mon_e.rdata);
          check("rd_strobes", rd_cnt, mon_e.nrd);
          check("wr_strobes", wr_cnt, mon_e.nwr);
          $display("txn port=%0d %s addr=%h rdata=%h cyc=%0d", mon_e.port,
                   mon_e.is_read ? "rd" : "wr", mon_e.addr, rdata, cyc);
        end
        rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  op_t nop, ra, rb, rnd0, rnd1;
  int  n0, n1;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    nop = mk(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_ack", {30'b0, ack}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_mem_read", {31'b0, mem_read}, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    mem_clr = 1'b0;
    rst = 1'b0;

    // contention straight out of reset: port 0 first
    run(2'b11, mk(1'b0, 4'h0, 32'h0, 32'h0), mk(1'b0, 4'h0, 32'h4, 32'h0));
    run(2'b01, mk(1'b1, 4'hF, 32'h0, 32'hDEADBEEF), nop);
    run(2'b01, mk(1'b0, 4'h0, 32'h0, 32'h0), nop);
    run(2'b01, mk(1'b1, 4'hF, 32'h4, 32'h12345678), nop);
    run(2'b10, nop, mk(1'b1, 4'b0010, 32'h4, 32'h0000AB00));
    run(2'b10, nop, mk(1'b0, 4'h0, 32'h4, 32'h0));
    // port 0 served last, so port 1 wins the next tie
    run(2'b01, mk(1'b0, 4'h0, 32'h0, 32'h0), nop);
    run(2'b11, mk(1'b0, 4'h0, 32'h0, 32'h0), mk(1'b0, 4'h0, 32'h4, 32'h0));
    run(2'b01, mk(1'b1, 4'h0, 32'h0, 32'hFFFFFFFF), nop);
    run(2'b01, mk(1'b0, 4'h0, 32'h0, 32'h0), nop);

    // reset during the WRITE phase of a partial store to 0x8
    @(negedge clk);
    we = 2'b01; be0 = 4'b0001; addr0 = 32'h8; wdata0 = 32'h000000FF; req = 2'b01;
    @(negedge clk);
    check("rm_busy_access", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("rm_write_strobe", {31'b0, mem_write}, 32'h1);
    rst = 1'b1; req = 2'b00;
    #1;
    check("rm_write_gated", {31'b0, mem_write}, 32'h0);
    @(negedge clk);
    check("rm_busy_after", {31'b0, busy}, 32'h0);
    check("rm_ack_after", {30'b0, ack}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rr_last = 1;
    run(2'b01, mk(1'b0, 4'h0, 32'h8, 32'h0), nop);

    // out-of-range store and readback
    run(2'b01, mk(1'b1, 4'hF, 32'h50, 32'hCAFEBABE), nop);
    run(2'b01, mk(1'b0, 4'h0, 32'h50, 32'h0), nop);

    for (int t = 0; t < 150; t++) begin
      for (int p = 0; p < 2; p++) begin
        op_t o;
        int  sel;
        sel = $urandom_range(0, 3);
        o.we = 1'($urandom_range(0, 1));
        o.be = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
        o.addr = 32'($urandom_range(0, 32'h5F));
        o.wdata = $urandom;
        if (p == 0) rnd0 = o; else rnd1 = o;
      end
      run(2'($urandom_range(1, 3)), rnd0, rnd1);
    end

    // fixed priority: port 0 requesting continuously starves port 1
    @(negedge clk);
    fp_req = 2'b11;
    n0 = 0; n1 = 0;
    repeat (30) begin
      @(negedge clk);
      if (fp_ack[0]) n0++;
      if (fp_ack[1]) n1++;
    end
    fp_req = 2'b00;
    check("fp_port1_starved", n1, 0);
    check("fp_port0_served", n0, 10);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `dmem`. It shares the memory between port 0 (core load/store unit) and port 1 (debug/DMA loader). It adds byte-enable stores by running a read-modify-write on the word-only `dmem`. The block sits between the requesters and `dmem`; it owns the `mem_read`, `mem_write`, `addr` and `write_data` pins, and consumes `read_data`.

## Interface
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req[1:0]`  in  2  per-port request; held high and stable until that port's `ack`.
- `we[1:0]`  in  2  per-port write flag.
- `be0`, `be1`  in  4 each  byte enables for a write; bit n covers bits [8n+7:8n]; ignored for reads.
- `addr0`, `addr1`  in  32 each  byte address; bits [1:0] ignored (word access).
- `wdata0`, `wdata1`  in  32 each  write data, already lane-aligned.
- `ack[1:0]`  out  2  one-cycle completion pulse to the served port.
- `rdata`  out  32  read result; valid only in the `ack` cycle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `mem_read`, `mem_write`  out  1 each  to `dmem`.
- `mem_addr`, `mem_wdata`  out  32 each  to `dmem` `addr` / `write_data`.
- `mem_rdata`  in  32  from `dmem` `read_data` (combinational read).

## Operation
- **Reset values:** state = IDLE, `ack` = 0, `rdata` = 0, `busy` = 0, `mem_read` = `mem_write` = 0, `mem_addr` = `mem_wdata` = 0, RR pointer = 1 (so port 0 wins the first tie).
- **IDLE:**
  - No request: stay in IDLE.
  - One port requesting: grant it.
  - Both requesting: grant the port not served last (`RR_EN`=1), or port 0 (`RR_EN`=0).
  - On grant, latch the winner's `we`, `be`, `addr` (with [1:0] forced to 0) and `wdata`, then go to ACCESS.
- **ACCESS:** drive `mem_addr` = latched address, then branch on the request type:
  - Read: `mem_read`=1, capture `mem_rdata` into `rdata`, go to DONE.
  - Full write (`be`=4'hF): `mem_write`=1, `mem_wdata` = latched data, go to DONE.
  - Partial write (`be` not 0 and not F): `mem_read`=1, register merged word (bytes with `be` set come from `wdata`, the others from `mem_rdata`), go to WRITE.
  - Null write (`be`=0): no memory strobe, go to DONE.
- **WRITE:** `mem_write`=1, `mem_wdata` = merged word, go to DONE.
- **DONE:** pulse `ack[winner]` for one cycle, update the RR pointer to the winner, go to IDLE.
- **Request drop:** a port that drops `req` before `ack` has no effect on the operation in flight; it completes and `ack` still pulses.
- **Reset gating:** `mem_read` and `mem_write` are combinationally gated with `!rst`, so no `dmem` write commits on a reset edge. A reset during WRITE abandons that store and memory keeps its old word.
- **Out of range:** out-of-range addresses behave as in `dmem`: reads return 0 and writes are dropped. The arbiter still acks normally.

## Timing
- `req` is sampled in IDLE at edge T.
- Read, full write and null write: `ack` high during cycle T+2. Read `rdata` is valid in that same cycle.
- Partial write: `ack` high during T+3.
- Back-to-back: DONE returns to IDLE, so the next grant is sampled one cycle after `ack`. Peak throughput is one access per 3 cycles (4 for partial writes).
- A waiting port is served no later than after one access by the other port (`RR_EN`=1). Port 1 can starve when `RR_EN`=0.
- `ack` is never high for both ports in the same cycle.

## Structure
- Package `dmem_arb_pkg` holds:
  - state enum (IDLE, ACCESS, WRITE, DONE), 2-bit encoding;
  - `BE_FULL` = 4'hF and `BE_NONE` = 4'h0;
  - port-index constants.
- One combinational sub-module, `byte_merge` (inputs `old`, `new`, `be`; output `merged`), is instantiated once for the ACCESS merge.
- The FSM, arbiter and `dmem` pin muxing live in `dmem_arbiter`.

## Test plan
All scenarios use a `dmem` with DEPTH=16 behind the arbiter.
- **Full write then read:** port 0 writes 0xDEADBEEF at 0x0 with `be`=F. Expect `ack[0]` at T+2. A port 0 read of 0x0 then returns `rdata`=0xDEADBEEF with `ack[0]` at T+2.
- **Partial write:** memory at 0x4 holds 0x12345678; port 1 writes `wdata`=0x0000AB00 with `be`=4'b0010. Expect `ack[1]` at T+3, and a readback of 0x4 returns 0x1234AB78.
- **Simultaneous requests:** both ports request reads of 0x0 and 0x4 from reset.
  - `RR_EN`=1: port 0 is acked first, then port 1, and the RR pointer alternates on repeated contention.
  - `RR_EN`=0 with port 0 requesting continuously: port 1 is never acked.
- **Null write:** `be`=0 write of 0xFFFFFFFF to 0x0. Expect `ack` at T+2, no `mem_write` pulse, and 0x0 unchanged.
- **Reset mid-operation:** assert `rst` during the WRITE state of a partial store to 0x8 (old value 0x0). Expect `busy`=0 and `ack`=0 after the edge, and 0x8 still reads 0x00000000.
- **Out-of-range write:** write 0xCAFEBABE to 0x50. Expect `ack` at T+2, and a readback of 0x50 returns 0x00000000.
